// File: rtl/mining_pkg.sv
// mining_pkg
//   Shared constants and types for the Memoria block-store port.
//   ROW_BITS      : width of one stored row
//   WORD_BITS     : width of one word on the write stream
//   WORDS_PER_ROW : words packed into one row
//   IDX_W         : width of the word index inside a row
//   rd_state_t    : read state machine encoding
package mining_pkg;

  localparam int ROW_BITS      = 512;
  localparam int WORD_BITS     = 32;
  localparam int WORDS_PER_ROW = ROW_BITS / WORD_BITS;
  localparam int IDX_W         = $clog2(WORDS_PER_ROW);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HOLD
  } rd_state_t;

endpackage

// File: rtl/bram_wr_packer.sv
// bram_wr_packer
//   Write pointer for the row packer: row counter, word index within the row,
//   the MSB of the slice the current word lands in, and the full flag.
//   clock     : rising-edge clock
//   reset     : synchronous active-high reset
//   clear     : synchronous pointer clear
//   accept    : a word is transferred this cycle
//   wr_row    : row the next word goes to (also the count of complete rows)
//   slice_msb : top bit of the slice for the next word (first word = MSB slice)
//   full      : every row has been written
module bram_wr_packer
  import mining_pkg::*;
#(
  parameter int DEPTH  = 500,
  parameter int ADDR_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              accept,
  output logic [ADDR_W-1:0] wr_row,
  output logic [8:0]        slice_msb,
  output logic              full
);

  logic [IDX_W-1:0] wr_idx;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wr_row <= '0;
      wr_idx <= '0;
    end else if (accept) begin
      if (wr_idx == IDX_W'(WORDS_PER_ROW - 1)) begin
        wr_idx <= '0;
        wr_row <= wr_row + 1'b1;
      end else begin
        wr_idx <= wr_idx + 1'b1;
      end
    end
  end

  assign slice_msb = 9'(ROW_BITS - 1 - WORD_BITS * int'(wr_idx));

  // No wrap-around: once the last row is complete the writer stays blocked.
  assign full = (wr_row >= ADDR_W'(DEPTH));

endmodule

// File: rtl/bram_block_port.sv
// bram_block_port
//   Initiator-side controller for the 512-bit Memoria block store. Packs a
//   32-bit word stream into rows and fetches whole rows for the hash datapath.
//   clock, reset, clear           : clock, sync active-high reset, pointer clear
//   wr_valid/wr_ready/wr_word      : incoming word stream
//   rd_req/rd_row                  : fetch request, sampled while idle
//   rd_busy/rd_err                 : fetch in progress / bad-row pulse
//   block_valid/block_ready/data   : fetched row handshake
//   blocks_stored                  : complete rows written
//   addr..bram_data_in, cs_n/wr_n/rd_n : registered memory strobes
//   bram_data_out                  : row returned by the store
module bram_block_port
  import mining_pkg::*;
#(
  parameter int DEPTH  = 500,
  parameter int ADDR_W = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [WORD_BITS-1:0] wr_word,
  input  logic                 rd_req,
  input  logic [ADDR_W-1:0]    rd_row,
  output logic                 rd_busy,
  output logic                 rd_err,
  output logic                 block_valid,
  input  logic                 block_ready,
  output logic [ROW_BITS-1:0]  block_data,
  output logic [ADDR_W-1:0]    blocks_stored,
  output logic [ADDR_W-1:0]    addr,
  output logic [8:0]           addr_width,
  output logic                 cs_n,
  output logic                 wr_n,
  output logic                 rd_n,
  output logic [WORD_BITS-1:0] bram_data_in,
  input  logic [ROW_BITS-1:0]  bram_data_out
);

  rd_state_t         state, state_next;
  logic [ADDR_W-1:0] wr_row;
  logic [8:0]        slice_msb;
  logic              full;
  logic              accept;
  logic              rd_hit;
  logic              rd_miss;

  bram_wr_packer #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_packer (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .accept    (accept),
    .wr_row    (wr_row),
    .slice_msb (slice_msb),
    .full      (full)
  );

  // Rows are filled strictly in order, so the row pointer is the stored count.
  assign blocks_stored = wr_row;

  // A pending read request always takes the cycle away from the writer.
  assign wr_ready = !reset && !clear && (state == IDLE) && !rd_req && !full;
  assign accept   = wr_valid && wr_ready;
  assign rd_hit   = (state == IDLE) && rd_req && (rd_row <  blocks_stored);
  assign rd_miss  = (state == IDLE) && rd_req && (rd_row >= blocks_stored);
  assign rd_busy  = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset || clear) state <= IDLE;
    else                state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (rd_hit) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    state_next = HOLD;
      HOLD:    if (block_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobes are registered: the decision made in IDLE shows up on the pins
  // during ISSUE, and the store answers one cycle later during WAIT.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      cs_n         <= 1'b1;
      wr_n         <= 1'b1;
      rd_n         <= 1'b1;
      addr         <= '0;
      addr_width   <= '0;
      bram_data_in <= '0;
      rd_err       <= 1'b0;
      block_valid  <= 1'b0;
      block_data   <= '0;
    end else begin
      cs_n   <= 1'b1;
      wr_n   <= 1'b1;
      rd_n   <= 1'b1;
      rd_err <= rd_miss;
      if (accept) begin
        addr         <= wr_row;
        addr_width   <= slice_msb;
        bram_data_in <= wr_word;
        cs_n         <= 1'b0;
        wr_n         <= 1'b0;
      end else if (rd_hit) begin
        addr <= rd_row;
        cs_n <= 1'b0;
        rd_n <= 1'b0;
      end
      if (state == WAIT) begin
        block_data  <= bram_data_out;
        block_valid <= 1'b1;
      end else if ((state == HOLD) && block_ready) begin
        block_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bram_block_port.sv
module tb_bram_block_port;

  localparam int DEPTH  = 4;
  localparam int ADDR_W = 16;

  logic               clock = 1'b0;
  logic               reset = 1'b1;
  logic               clear = 1'b0;
  logic               wr_valid = 1'b0;
  logic               wr_ready;
  logic [31:0]        wr_word = '0;
  logic               rd_req = 1'b0;
  logic [ADDR_W-1:0]  rd_row = '0;
  logic               rd_busy;
  logic               rd_err;
  logic               block_valid;
  logic               block_ready = 1'b1;
  logic [511:0]       block_data;
  logic [ADDR_W-1:0]  blocks_stored;
  logic [ADDR_W-1:0]  addr;
  logic [8:0]         addr_width;
  logic               cs_n;
  logic               wr_n;
  logic               rd_n;
  logic [31:0]        bram_data_in;
  logic [511:0]       bram_data_out;

  bram_block_port #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock         (clock),
    .reset         (reset),
    .clear         (clear),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_word       (wr_word),
    .rd_req        (rd_req),
    .rd_row        (rd_row),
    .rd_busy       (rd_busy),
    .rd_err        (rd_err),
    .block_valid   (block_valid),
    .block_ready   (block_ready),
    .block_data    (block_data),
    .blocks_stored (blocks_stored),
    .addr          (addr),
    .addr_width    (addr_width),
    .cs_n          (cs_n),
    .wr_n          (wr_n),
    .rd_n          (rd_n),
    .bram_data_in  (bram_data_in),
    .bram_data_out (bram_data_out)
  );

  always #5 clock = ~clock;

  // Behavioural store: word writes into a slice, synchronous row read.
  logic [511:0] mem [0:DEPTH-1];
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
    bram_data_out = '0;
  end
  always @(posedge clock) begin
    if (!cs_n && !wr_n && addr < DEPTH) mem[addr][addr_width -: 32] <= bram_data_in;
    if (!cs_n && !rd_n && addr < DEPTH) bram_data_out <= mem[addr];
  end

  // Reference model: rows built from the accepted word stream.
  logic [511:0] exp_mem [0:DEPTH-1];
  logic [511:0] m_cur = '0;
  int           m_row = 0;
  int           m_idx = 0;
  int           n_pass = 0;
  int           n_total = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic model_clear();
    m_row = 0;
    m_idx = 0;
    m_cur = '0;
  endtask

  task automatic write_word(input logic [31:0] w);
    int waited;
    int e_row;
    int e_w;
    waited   = 0;
    wr_valid = 1'b1;
    wr_word  = w;
    #1;
    while (!wr_ready && waited < 40) begin
      tick();
      waited++;
    end
    n_total++;
    if (!wr_ready) begin
      $display("FAIL wr_accept_timeout: wr_ready=%b required 1", wr_ready);
      wr_valid = 1'b0;
      return;
    end else n_pass++;
    e_row = m_row;
    e_w   = 511 - 32 * m_idx;
    tick();
    wr_valid = 1'b0;
    n_total++;
    if ({cs_n, wr_n, rd_n} !== 3'b001) $display("FAIL wr_strobes: cs/wr/rd=%b required 001", {cs_n, wr_n, rd_n});
    else n_pass++;
    n_total++;
    if (addr !== ADDR_W'(e_row)) $display("FAIL wr_addr: got %0d required %0d", addr, e_row);
    else n_pass++;
    n_total++;
    if (addr_width !== 9'(e_w)) $display("FAIL wr_addr_width: got %0d required %0d", addr_width, e_w);
    else n_pass++;
    n_total++;
    if (bram_data_in !== w) $display("FAIL wr_data: got %h required %h", bram_data_in, w);
    else n_pass++;
    m_cur = (m_cur << 32) | 512'(w);
    m_idx++;
    if (m_idx == 16) begin
      exp_mem[m_row] = m_cur;
      m_row++;
      m_idx = 0;
      m_cur = '0;
    end
    n_total++;
    if (blocks_stored !== ADDR_W'(m_row)) $display("FAIL blocks_stored: got %0d required %0d", blocks_stored, m_row);
    else n_pass++;
  endtask

  task automatic write_random_row();
    for (int i = 0; i < 16; i++) write_word($urandom);
  endtask

  task automatic read_row(input int row, input int hold);
    rd_req      = 1'b1;
    rd_row      = ADDR_W'(row);
    block_ready = 1'b0;
    #1;
    n_total++;
    if (wr_ready !== 1'b0) $display("FAIL rd_blocks_wr: wr_ready=%b required 0", wr_ready);
    else n_pass++;
    tick();
    rd_req = 1'b0;
    n_total++;
    if ({cs_n, wr_n, rd_n} !== 3'b010) $display("FAIL rd_strobes: cs/wr/rd=%b required 010", {cs_n, wr_n, rd_n});
    else n_pass++;
    n_total++;
    if (addr !== ADDR_W'(row)) $display("FAIL rd_addr: got %0d required %0d", addr, row);
    else n_pass++;
    n_total++;
    if (rd_busy !== 1'b1) $display("FAIL rd_busy_issue: got %b required 1", rd_busy);
    else n_pass++;
    tick();
    n_total++;
    if ({block_valid, cs_n} !== 2'b01) $display("FAIL rd_wait: valid/cs_n=%b required 01", {block_valid, cs_n});
    else n_pass++;
    tick();
    n_total++;
    if (block_valid !== 1'b1) $display("FAIL rd_latency: block_valid=%b required 1", block_valid);
    else n_pass++;
    n_total++;
    if (block_data !== exp_mem[row]) $display("FAIL rd_data row %0d: got %h required %h", row, block_data, exp_mem[row]);
    else n_pass++;
    for (int i = 0; i < hold; i++) begin
      tick();
      n_total++;
      if ({block_valid, rd_busy, wr_ready} !== 3'b110)
        $display("FAIL rd_hold: valid/busy/wr_ready=%b required 110", {block_valid, rd_busy, wr_ready});
      else n_pass++;
      n_total++;
      if (block_data !== exp_mem[row]) $display("FAIL rd_hold_data: got %h required %h", block_data, exp_mem[row]);
      else n_pass++;
    end
    block_ready = 1'b1;
    tick();
    n_total++;
    if ({block_valid, rd_busy} !== 2'b00) $display("FAIL rd_done: valid/busy=%b required 00", {block_valid, rd_busy});
    else n_pass++;
  endtask

  task automatic bad_read(input int row);
    rd_req = 1'b1;
    rd_row = ADDR_W'(row);
    #1;
    n_total++;
    if (wr_ready !== 1'b0) $display("FAIL bad_blocks_wr: wr_ready=%b required 0", wr_ready);
    else n_pass++;
    tick();
    rd_req = 1'b0;
    n_total++;
    if ({rd_err, rd_busy, cs_n} !== 3'b101) $display("FAIL bad_pulse row %0d: err/busy/cs_n=%b required 101", row, {rd_err, rd_busy, cs_n});
    else n_pass++;
    tick();
    n_total++;
    if ({rd_err, rd_busy, cs_n} !== 3'b001) $display("FAIL bad_after row %0d: err/busy/cs_n=%b required 001", row, {rd_err, rd_busy, cs_n});
    else n_pass++;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    wr_valid = 1'b1;
    tick();
    tick();
    n_total++;
    if (wr_ready !== 1'b0) $display("FAIL reset_wr_ready: got %b required 0", wr_ready);
    else n_pass++;
    n_total++;
    if ({cs_n, wr_n, rd_n, block_valid, rd_err, rd_busy} !== 6'b111000)
      $display("FAIL reset_flags: got %b required 111000", {cs_n, wr_n, rd_n, block_valid, rd_err, rd_busy});
    else n_pass++;
    n_total++;
    if ({addr, addr_width, bram_data_in, blocks_stored} !== '0)
      $display("FAIL reset_regs: addr=%0d width=%0d data=%h stored=%0d required 0", addr, addr_width, bram_data_in, blocks_stored);
    else n_pass++;
    n_total++;
    if (block_data !== '0) $display("FAIL reset_block_data: got %h required 0", block_data);
    else n_pass++;
    reset    = 1'b0;
    wr_valid = 1'b0;
    #1;
    n_total++;
    if (wr_ready !== 1'b1) $display("FAIL post_reset_wr_ready: got %b required 1", wr_ready);
    else n_pass++;
    model_clear();
  endtask

  task automatic test_load_one_row();
    for (int i = 1; i <= 16; i++) write_word(32'(i));
    read_row(0, 0);
  endtask

  task automatic test_bad_row();
    write_random_row();
    bad_read(5);
    bad_read(2);
  endtask

  task automatic test_read_vs_write();
    logic [31:0] w;
    w        = $urandom;
    wr_valid = 1'b1;
    wr_word  = w;
    read_row(1, 2);
    #1;
    n_total++;
    if (wr_ready !== 1'b1) $display("FAIL rvw_wr_ready_after: got %b required 1", wr_ready);
    else n_pass++;
    write_word(w);
    for (int i = 0; i < 15; i++) write_word($urandom);
  endtask

  task automatic test_backpressure();
    wr_valid = 1'b1;
    read_row(2, 10);
    wr_valid = 1'b0;
  endtask

  task automatic test_fill_refuse();
    write_random_row();
    wr_valid = 1'b1;
    wr_word  = $urandom;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_total++;
      if (wr_ready !== 1'b0) $display("FAIL full_wr_ready: got %b required 0", wr_ready);
      else n_pass++;
      tick();
      n_total++;
      if ({cs_n, blocks_stored} !== {1'b1, ADDR_W'(DEPTH)})
        $display("FAIL full_ignored: cs_n=%b stored=%0d required 1/%0d", cs_n, blocks_stored, DEPTH);
      else n_pass++;
    end
    wr_valid = 1'b0;
    read_row(3, 0);
    clear = 1'b1;
    #1;
    n_total++;
    if (wr_ready !== 1'b0) $display("FAIL clear_wr_ready: got %b required 0", wr_ready);
    else n_pass++;
    tick();
    clear = 1'b0;
    #1;
    model_clear();
    n_total++;
    if ({wr_ready, cs_n, blocks_stored} !== {2'b11, ADDR_W'(0)})
      $display("FAIL after_clear: wr_ready=%b cs_n=%b stored=%0d required 1/1/0", wr_ready, cs_n, blocks_stored);
    else n_pass++;
    bad_read(0);
  endtask

  task automatic test_reset_mid_row();
    for (int i = 0; i < 7; i++) write_word($urandom);
    reset    = 1'b1;
    wr_valid = 1'b1;
    wr_word  = $urandom;
    tick();
    n_total++;
    if ({cs_n, wr_ready, blocks_stored} !== {2'b10, ADDR_W'(0)})
      $display("FAIL mid_reset: cs_n=%b wr_ready=%b stored=%0d required 1/0/0", cs_n, wr_ready, blocks_stored);
    else n_pass++;
    reset    = 1'b0;
    wr_valid = 1'b0;
    model_clear();
    write_random_row();
    read_row(0, 2);
  endtask

  task automatic test_random_reads();
    write_random_row();
    write_random_row();
    for (int i = 0; i < 6; i++) read_row($urandom_range(m_row - 1, 0), $urandom_range(3, 0));
  endtask

  initial begin
    test_reset();
    test_load_one_row();
    test_bad_row();
    test_read_vs_write();
    test_backpressure();
    test_fill_refuse();
    test_reset_mid_row();
    test_random_reads();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/bram_block_port.md
# bram_block_port

Initiator-side controller for the 512-bit-wide `Memoria` block store in Mining 3.0.
- Write side: packs an incoming 32-bit word stream into 512-bit rows, 16 words per row, first word in the most significant slice.
- Read side: fetches a whole stored row on request and presents it to the hash datapath with a valid/ready handshake.
- Owns all memory strobes; nothing else drives the store.

## Interface
- `DEPTH`, 500: number of rows in the store; matches the store's row count.
- `ADDR_W`, 16: row address width.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `clear`  in  1  synchronous pointer clear; memory contents are untouched.
- `wr_valid` in 1, `wr_ready` out 1, `wr_word` in 32: word stream; transfer when valid&&ready.
- `rd_req`  in  1  fetch request for one cycle, sampled only when `rd_busy`=0.
- `rd_row`  in  ADDR_W  row to fetch, sampled with `rd_req`.
- `rd_busy`  out  1  a fetch is in progress or a block is held.
- `rd_err`  out  1  one-cycle pulse: request for a row that is not stored.
- `block_valid` out 1, `block_ready` in 1, `block_data` out 512: fetched row; transfer when valid&&ready.
- `blocks_stored`  out  ADDR_W  count of complete rows written.
- `addr` out ADDR_W, `addr_width` out 9, `cs_n` out 1, `wr_n` out 1, `rd_n` out 1, `bram_data_in` out 32: memory strobes, all registered.
- `bram_data_out`  in  512  row data returned by the store.

## Operation
- **Write pointer** is (`wr_row`, `wr_idx`), where `wr_idx` runs 0..15.
  - An accepted word drives `addr`=`wr_row`, `addr_width`=511-32*`wr_idx`, `bram_data_in`=`wr_word`, `cs_n`=0, `wr_n`=0, `rd_n`=1.
  - When `wr_idx`=15, the pointer wraps to 0, `wr_row` increments and `blocks_stored` increments.
- **`wr_ready`** = !reset && !clear && state==IDLE && !rd_req && `wr_row`<DEPTH.
  - A read request wins over a write in the same cycle.
  - Full (`wr_row`=DEPTH) holds `wr_ready` low until `clear` or `reset`; there is no wrap-around.
- **Read state machine**:
  - **IDLE**: `rd_req` with `rd_row`<`blocks_stored` goes to **ISSUE**. `rd_req` with `rd_row`>=`blocks_stored` pulses `rd_err` the next cycle and stays in IDLE with no memory access.
  - **ISSUE**: drive `cs_n`=0, `rd_n`=0, `wr_n`=1, `addr`=`rd_row`; go to **WAIT**.
  - **WAIT**: register `bram_data_out` into `block_data`, set `block_valid`; go to **HOLD**.
  - **HOLD**: keep `block_data` stable while `block_valid`=1. When `block_ready`=1, clear `block_valid` and return to IDLE.
- **`rd_busy`** = state!=IDLE.
- **Idle strobes**: in any cycle without an access, `cs_n`=`wr_n`=`rd_n`=1 and `addr`/`addr_width`/`bram_data_in` hold their last values.
- **`clear`** has the same effect as `reset` on pointers, `blocks_stored`, state, `block_valid`, `rd_err` and strobes. Any fetch in progress is abandoned.

## Timing
- **Reset values**: `cs_n`=`wr_n`=`rd_n`=1; `addr`=0; `addr_width`=0; `bram_data_in`=0; `block_data`=0; `block_valid`=0; `rd_err`=0; `rd_busy`=0; `blocks_stored`=0; `wr_ready`=0 while reset is high; state IDLE.
- **Write latency**: a word accepted in cycle N appears on the strobes in cycle N+1.
  - Back-to-back words: one per cycle, 16 cycles per row.
  - `blocks_stored` updates in cycle N+1 after the 16th word.
- **Read latency**: `rd_req` in cycle N, ISSUE strobes in N+1, store output valid in N+2, `block_valid`=1 in N+3. With `block_ready` held high, `rd_busy` falls in N+4.
- A read accepted in cycle N while a write beat from N-1 is on the strobes causes no conflict; the strobes are registered, so the write occupies N and the read N+1.
- **Reset or `clear` in any state**: outputs take reset values on the next edge. A write beat registered that same edge is dropped (`cs_n`=1); the partially filled row is not counted.
- `rd_err` and a write acceptance never occur in the same cycle, because `rd_req` blocks `wr_ready`.

## Structure
- Shared package `mining_pkg`: `ROW_BITS`=512, `WORD_BITS`=32, `WORDS_PER_ROW`=16, and the read-state enum (IDLE, ISSUE, WAIT, HOLD).
- One sub-module, `bram_wr_packer`: the `wr_row`/`wr_idx` counters, `addr_width` computation and full detection.
- The top level holds arbitration, the read state machine and the strobe registers.

## Test plan
- **Load one row.** After reset, stream 16 words 0x00000001..0x00000010 back-to-back.
  - Strobe cycles carry `addr_width` 511,479,…,31.
  - `blocks_stored`=1.
  - Fetch row 0: `block_data`=0x00000001_00000002_…_00000010, `block_valid` exactly 3 cycles after `rd_req`.
- **Fill and refuse.** Fill DEPTH=4 rows (parameter override).
  - `wr_ready`=0 after the 64th word, and `wr_valid` is then ignored.
  - `clear` restores `wr_ready`=1 and `blocks_stored`=0.
- **Bad row.** `rd_req` with `rd_row`=5 while `blocks_stored`=2.
  - `rd_err` pulses one cycle.
  - No `cs_n` low cycle; `rd_busy` stays 0.
- **Read vs write same cycle.** `rd_req` and `wr_valid` both high in IDLE.
  - `wr_ready`=0 that cycle; the read strobes come first.
  - The word is accepted after `block_ready` returns the machine to IDLE.
- **Backpressure.** Hold `block_ready`=0 for 10 cycles: `block_data` stable, `rd_busy`=1, `wr_ready`=0 throughout.
- **Reset mid-row.** Assert `reset` after 7 words of row 0.
  - Next cycle `cs_n`=1 and `blocks_stored`=0.
  - The next 16 words rewrite row 0 from `addr_width`=511.
